// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and programmable bit period.
// Define UART_PARITY_EN to add a parity bit selected by CTRL[2].
module uart_tx_dev #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16,
    parameter int DIV_RESET  = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        txd
);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef UART_PARITY_EN
    localparam int CW = 3;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    localparam int CW = 2;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t              state;
    logic [7:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         count;
    logic                overflow;
    logic [CW-1:0]       ctrl;
    logic [DIV_W-1:0]    div, eff_div, period, cnt;
    logic [7:0]          shift;
    logic [2:0]          idx;
    logic                full, empty, pop, push;
    logic                wr_data, wr_stat, wr_div, wr_ctrl;
    logic                unused_bits;
`ifdef UART_PARITY_EN
    logic                par;
`endif

    assign unused_bits = ^{Addr[29:2], Din};

    assign wr_data = WE && (Addr[1:0] == 2'd0);
    assign wr_stat = WE && (Addr[1:0] == 2'd1);
    assign wr_div  = WE && (Addr[1:0] == 2'd2);
    assign wr_ctrl = WE && (Addr[1:0] == 2'd3);

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign pop     = (state == IDLE) && ctrl[0] && !empty;
    assign push    = wr_data && (!full || pop);
    assign eff_div = (div == '0) ? DIV_W'(1) : div;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= Din[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
            if (wr_data && full && !pop)  overflow <= 1'b1;
            else if (wr_stat && Din[3])   overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl <= '0;
            div  <= DIV_W'(DIV_RESET);
        end else begin
            if (wr_ctrl) ctrl <= Din[CW-1:0];
            if (wr_div)  div  <= Din[DIV_W-1:0];
        end
    end

    // txd is registered: each branch loads the level for the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            txd    <= 1'b1;
            IRQ    <= 1'b0;
            shift  <= '0;
            period <= '0;
            cnt    <= '0;
            idx    <= '0;
`ifdef UART_PARITY_EN
            par    <= 1'b0;
`endif
        end else begin
            IRQ <= ctrl[1] && empty && (state == IDLE);
            unique case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        shift  <= mem[rd_ptr];
                        period <= eff_div;
                        cnt    <= eff_div - DIV_W'(1);
                        txd    <= 1'b0;
                        state  <= START;
`ifdef UART_PARITY_EN
                        par    <= ^mem[rd_ptr] ^ ctrl[2];
`endif
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        cnt   <= period - DIV_W'(1);
                        idx   <= '0;
                        txd   <= shift[0];
                        state <= DATA;
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        cnt <= period - DIV_W'(1);
                        if (idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            txd   <= par;
                            state <= PARITY;
`else
                            txd   <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            shift <= shift >> 1;
                            txd   <= shift[1];
                            idx   <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (cnt == '0) begin
                        cnt   <= period - DIV_W'(1);
                        txd   <= 1'b1;
                        state <= STOP;
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (cnt == '0) begin
                        txd   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        Dout = '0;
        unique case (Addr[1:0])
            2'd0: Dout = '0;
            2'd1: begin
                Dout[0]         = (state != IDLE);
                Dout[1]         = full;
                Dout[2]         = empty;
                Dout[3]         = overflow;
                Dout[7 +: AW+1] = count;
            end
            2'd2: Dout[DIV_W-1:0] = div;
            2'd3: Dout[CW-1:0]    = ctrl;
            default: Dout = '0;
        endcase
    end
endmodule
